// File: rtl/code_sram_ctl_pkg.sv
// Shared definitions for the code SRAM controller: FSM encoding and default geometry.
package code_sram_ctl_pkg;

   localparam int unsigned DEF_AW = 13;
   localparam int unsigned DEF_DW = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/code_sram_ctl_sram_1rw.sv
// Storage array: one write port, one registered read port (read-first on address collision).
module sram_1rw
   import code_sram_ctl_pkg::*;
#(
   parameter int unsigned AW = DEF_AW,
   parameter int unsigned DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1 << AW) - 1];

   // The array itself has no reset; only the controller's clear walk zeroes it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/code_sram_ctl.sv
// Code SRAM controller: post-reset zero-fill walk, then CPU port with a lower-priority loader port.
module code_sram_ctl
   import code_sram_ctl_pkg::*;
#(
   parameter int unsigned AW             = DEF_AW,
   parameter int unsigned DW             = DEF_DW,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] a,
   input  logic [DW-1:0] in,
   output logic [DW-1:0] out,
   input  logic          cs,
   input  logic          we,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic          busy
);

   localparam logic [AW-1:0] LAST_ADDR = '1;
   localparam state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] clr_cnt;
   logic [AW-1:0] clr_nxt;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          mem_re;
   logic          cpu_wr;

   assign cpu_wr = !cs && !we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RST_STATE;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_cnt;
      mem_we    = 1'b0;
      mem_waddr = a;
      mem_wdata = in;
      mem_re    = 1'b0;
      ld_ready  = 1'b0;
      busy      = 1'b0;

      case (state)
         ST_CLEAR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
            // Counter wraps back to 0 on the final write, leaving it ready for the next reset.
            clr_nxt   = clr_cnt + AW'(1);
            if (clr_cnt == LAST_ADDR) begin
               state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            mem_re   = !cs;
            ld_ready = !cpu_wr;
            if (cpu_wr) begin
               mem_we = 1'b1;
            end else if (ld_valid) begin
               mem_we    = 1'b1;
               mem_waddr = ld_addr;
               mem_wdata = ld_data;
            end
         end

         default: begin
            state_nxt = RST_STATE;
         end
      endcase
   end

   sram_1rw #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clk   (clk),
      .rst   (reset),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (a),
      .rdata (out)
   );

endmodule

// File: doc/code_sram_ctl.md
CODE_SRAM_CTL -- requirements
Module: code_sram_ctl

Interface
REQ-001 SHALL have parameter AW, default 13, address width (depth 2**AW words).
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, enables the post-reset zero-fill walk.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port a  input  AW  CPU address.
REQ-007 SHALL have port in  input  DW  CPU write data.
REQ-008 SHALL have port out  output  DW  CPU read data, registered.
REQ-009 SHALL have port cs  input  1  CPU chip select, active low.
REQ-010 SHALL have port we  input  1  CPU write enable, active low, qualified by cs.
REQ-011 SHALL have port ld_valid  input  1  loader write request.
REQ-012 SHALL have port ld_addr  input  AW  loader address.
REQ-013 SHALL have port ld_data  input  DW  loader write data.
REQ-014 SHALL have port ld_ready  output  1  loader write accepted this cycle.
REQ-015 SHALL have port busy  output  1  clear walk in progress.

Function
REQ-016 SHALL implement states CLEAR and RUN; CLEAR entered on reset when CLEAR_ON_RESET=1, else RUN.
REQ-017 In CLEAR SHALL write 0 to address clr_cnt each cycle, clr_cnt incrementing from 0; at clr_cnt = 2**AW-1 the write completes and state moves to RUN next cycle.
REQ-018 busy SHALL be 1 exactly while state is CLEAR.
REQ-019 In CLEAR: CPU writes ignored, ld_ready=0, out held at 0.
REQ-020 In RUN with cs=0 and we=0: ram[a] <= in at the clock edge.
REQ-021 In RUN with cs=0: out <= ram[a] at the edge (one-cycle read latency); with cs=1 out holds its value.
REQ-022 Read-during-write to the same address (either port) SHALL return old data (read-first).
REQ-023 ld_ready SHALL be combinational: 1 iff state=RUN and not (cs=0 and we=0).
REQ-024 ld_valid=1 and ld_ready=1 SHALL write ram[ld_addr] <= ld_data at the edge; loader may hold ld_valid until ld_ready.
REQ-025 CPU write SHALL have priority over loader; at most one memory write per cycle.
REQ-026 Address arithmetic SHALL be modulo 2**AW; clr_cnt wraps exactly once, no out-of-range access.

Reset
REQ-027 Reset SHALL force out=0, clr_cnt=0, state=CLEAR (busy=1) if CLEAR_ON_RESET=1, else state=RUN (busy=0).
REQ-028 Reset asserted mid-CLEAR SHALL restart the walk from address 0.
REQ-029 Memory array contents SHALL NOT be reset directly; only the clear walk zeroes them.

Structure
REQ-030 Shared package SHALL hold the state encoding (CLEAR, RUN) and default AW/DW constants.
REQ-031 Storage SHALL be one sub-module sram_1rw (single write port, single registered read port, parameters AW/DW); write-port mux and FSM live in code_sram_ctl.

Verification
REQ-032 Reset with AW=4, CLEAR_ON_RESET=1 -> busy=1 for exactly 16 cycles then 0; CPU reads of all 16 addresses return 0x00.
REQ-033 RUN: cs=0,we=0,a=0x005,in=0xA5; next cycle cs=0,we=1,a=0x005 -> out=0xA5 one cycle later.
REQ-034 CPU write a=0x010,in=0x11 and ld_valid=1,ld_addr=0x020,ld_data=0x22 same cycle -> ld_ready=0, only 0x010 written; next cycle (CPU idle) ld_ready=1, 0x020 becomes 0x22.
REQ-035 Same-address write 0x3C over 0x5A while reading -> out=0x5A that cycle, 0x3C on next read.
REQ-036 Reset asserted at clr_cnt=7 during CLEAR with AW=4 -> busy stays 1 for a further full 16 cycles after release.
REQ-037 CLEAR_ON_RESET=0 -> busy=0 and ld_ready=1 in the first cycle after reset release.
